// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: states, select
// encodings, opcode/funct constants, instruction classes and the select bundle.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_WB2    = 3'd5,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_EXT = 1'b1;

  localparam logic [1:0] REG_WRITE_ADDR_RD       = 2'd0;
  localparam logic [1:0] REG_WRITE_ADDR_RT       = 2'd1;
  localparam logic [1:0] REG_WRITE_ADDR_OVERFLOW = 2'd2;
  localparam logic [1:0] REG_WRITE_ADDR_NPC      = 2'd3;

  localparam logic [2:0] REG_WRITE_SRC_ALU  = 3'd0;
  localparam logic [2:0] REG_WRITE_SRC_MEM  = 3'd1;
  localparam logic [2:0] REG_WRITE_SRC_ZERO = 3'd2;
  localparam logic [2:0] REG_WRITE_SRC_ONE  = 3'd3;
  localparam logic [2:0] REG_WRITE_SRC_PC   = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // Instructions sharing a state sequence share a class.
  typedef enum logic [3:0] {
    IC_NONE,
    IC_ALU,
    IC_ADDI,
    IC_LW,
    IC_SW,
    IC_BEQ,
    IC_J,
    IC_JR,
    IC_JAL
  } iclass_e;

  typedef struct packed {
    logic [1:0] alu_ctl;
    logic       ext_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [2:0] reg_src;
    logic       npc_sel;
    logic       j_ctl;
    logic       jr_ctl;
  } sel_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: opcode/funct to class, legality and the
// static datapath select levels held for the whole instruction.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic       legal_o,
  output sel_t       sel_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    iclass_o = IC_NONE;
    legal_o  = 1'b0;
    sel_o    = '0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: begin
            iclass_o = IC_ALU;
            legal_o  = 1'b1;
          end
          FN_SUBU: begin
            iclass_o      = IC_ALU;
            legal_o       = 1'b1;
            sel_o.alu_ctl = ALU_SUB;
          end
          FN_JR: begin
            iclass_o     = IC_JR;
            legal_o      = 1'b1;
            sel_o.jr_ctl = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_LUI: begin
        iclass_o      = IC_ALU;
        legal_o       = 1'b1;
        sel_o.alu_ctl = (opcode_i == OP_LUI) ? ALU_LUI : ALU_OR;
        sel_o.alu_src = ALU_SRC_EXT;
        sel_o.reg_dst = REG_WRITE_ADDR_RT;
      end
      OP_ADDI: begin
        iclass_o      = IC_ADDI;
        legal_o       = 1'b1;
        sel_o.ext_op  = 1'b1;
        sel_o.alu_src = ALU_SRC_EXT;
        sel_o.reg_dst = REG_WRITE_ADDR_RT;
      end
      OP_LW: begin
        iclass_o      = IC_LW;
        legal_o       = 1'b1;
        sel_o.ext_op  = 1'b1;
        sel_o.alu_src = ALU_SRC_EXT;
        sel_o.reg_dst = REG_WRITE_ADDR_RT;
        sel_o.reg_src = REG_WRITE_SRC_MEM;
      end
      OP_SW: begin
        iclass_o      = IC_SW;
        legal_o       = 1'b1;
        sel_o.ext_op  = 1'b1;
        sel_o.alu_src = ALU_SRC_EXT;
      end
      OP_BEQ: begin
        iclass_o      = IC_BEQ;
        legal_o       = 1'b1;
        sel_o.alu_ctl = ALU_SUB;
        sel_o.ext_op  = 1'b1;
        sel_o.npc_sel = 1'b1;
      end
      OP_J: begin
        iclass_o    = IC_J;
        legal_o     = 1'b1;
        sel_o.j_ctl = 1'b1;
      end
      OP_JAL: begin
        iclass_o      = IC_JAL;
        legal_o       = 1'b1;
        sel_o.j_ctl   = 1'b1;
        sel_o.reg_dst = REG_WRITE_ADDR_NPC;
        sel_o.reg_src = REG_WRITE_SRC_PC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB/WB2, gates the
// architectural strobes into commit cycles, counts retirements, flags faults.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             overflow,
  input  logic             positive,
  input  logic             mem_ready,
  output logic [1:0]       alu_ctl,
  output logic             ext_op,
  output logic             alu_src,
  output logic [1:0]       reg_dst,
  output logic [2:0]       reg_src,
  output logic             npc_sel,
  output logic             j_ctl,
  output logic             jr_ctl,
  output logic             reg_write,
  output logic             mem_write,
  output logic             mem_req,
  output logic             pc_we,
  output logic             ir_we,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_e            state_q;
  iclass_e           iclass_q;
  sel_t              sel_q;
  logic              ov_q;
  logic              fault_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  cnt_q;

  iclass_e dec_class;
  logic    dec_legal;
  sel_t    dec_sel;
  sel_t    sel_cur;

  logic unused_positive;
  assign unused_positive = positive;

  mc_decode u_decode (
    .opcode_i (opcode),
    .funct_i  (funct),
    .iclass_o (dec_class),
    .legal_o  (dec_legal),
    .sel_o    (dec_sel)
  );

  // Strobes depend only on registered state and latched class, except the sw
  // commit, which must coincide with the cycle the memory reports ready.
  always_comb begin
    sel_cur   = '0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      ST_FETCH:  ir_we = rst;
      ST_DECODE: sel_cur = dec_sel;
      ST_EXEC: begin
        sel_cur = sel_q;
        case (iclass_q)
          IC_BEQ, IC_J, IC_JR: pc_we = 1'b1;
          IC_JAL: begin
            pc_we     = 1'b1;
            reg_write = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        sel_cur = sel_q;
        mem_req = 1'b1;
        if (mem_ready && iclass_q == IC_SW) begin
          mem_write = 1'b1;
          pc_we     = 1'b1;
        end
      end
      ST_WB: begin
        sel_cur = sel_q;
        if (iclass_q == IC_ADDI) begin
          reg_write = !ov_q;
        end else begin
          reg_write = 1'b1;
          pc_we     = 1'b1;
        end
      end
      ST_WB2: begin
        sel_cur         = sel_q;
        sel_cur.reg_dst = REG_WRITE_ADDR_OVERFLOW;
        sel_cur.reg_src = ov_q ? REG_WRITE_SRC_ONE : REG_WRITE_SRC_ZERO;
        reg_write       = 1'b1;
        pc_we           = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      iclass_q <= IC_NONE;
      sel_q    <= '0;
      ov_q     <= 1'b0;
      fault_q  <= 1'b0;
      wait_q   <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          iclass_q <= dec_class;
          sel_q    <= dec_sel;
          if (!dec_legal) begin
            state_q <= ST_HALT;
            fault_q <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          ov_q   <= overflow;
          wait_q <= '0;
          case (iclass_q)
            IC_BEQ, IC_J, IC_JR, IC_JAL: state_q <= ST_FETCH;
            IC_LW, IC_SW:                state_q <= ST_MEM;
            default:                     state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_q <= (iclass_q == IC_SW) ? ST_FETCH : ST_WB;
          end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
            state_q <= ST_HALT;
            fault_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_WB:   state_q <= (iclass_q == IC_ADDI) ? ST_WB2 : ST_FETCH;
        ST_WB2:  state_q <= ST_FETCH;
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign alu_ctl   = sel_cur.alu_ctl;
  assign ext_op    = sel_cur.ext_op;
  assign alu_src   = sel_cur.alu_src;
  assign reg_dst   = sel_cur.reg_dst;
  assign reg_src   = sel_cur.reg_src;
  assign npc_sel   = sel_cur.npc_sel;
  assign j_ctl     = sel_cur.j_ctl;
  assign jr_ctl    = sel_cur.jr_ctl;
  assign fault     = fault_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule
